axis_master_mem: RTL and testbench

AXI4-Stream master that streams a block of words from an internal, software-loadable memory. On a `start` pulse it reads `length` consecutive words from `start_addr`, wrapping modulo DEPTH, and presents them on the master stream with `m_axis_tlast` on the final beat. It is the transmit-side counterpart of `axis_slave_mem`, which captures a stream into memory. It feeds that block, or any AXI4-Stream sink, in loopback and traffic-generation setups.

---
 rtl/axis_master_mem.sv | 191 +++++++++++++++++++
 tb/tb_axis_master_mem.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_master_mem.sv
// AXI4-Stream master that replays a block of words from a software-loadable memory.
// A start request streams `length` words from `start_addr`, wrapping modulo DEPTH, with tlast on the final beat.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; memory writes accepted
// RUN   | issuing reads into the 2-entry skid FIFO, draining it to the stream
// FIN   | one-cycle done pulse, then back to IDLE

module axis_master_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                  m_axis_aclk,
   input  logic                  m_axis_areset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [ADDR_W:0]       length,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_W-1:0]     m_axis_tdata,
   output logic [DATA_W/8-1:0]   m_axis_tstrb,
   output logic [DATA_W/8-1:0]   m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_ZERO = '0;
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     rd_left_q, rd_left_d;
   logic [ADDR_W:0]     tx_left_q, tx_left_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   rd_data_q;
   logic                rd_vld_q;
   logic                rd_last_q;

   logic [1:0]          occ_q, occ_d;
   logic [DATA_W-1:0]   hd_data_q, hd_data_d;
   logic                hd_last_q, hd_last_d;
   logic [DATA_W-1:0]   tl_data_q, tl_data_d;
   logic                tl_last_q, tl_last_d;

   logic [ADDR_W:0]     len_clamp;
   logic                pop;
   logic                push;
   logic [2:0]          occ_sum;
   logic                rd_issue;

   assign len_clamp = (length > DEPTH_L) ? DEPTH_L : length;
   assign pop       = (occ_q != 2'd0) && m_axis_tready;
   assign push      = rd_vld_q;

   // Occupancy after this edge; a read is only issued if its data will find a free slot.
   assign occ_sum   = {1'b0, occ_q} + {2'b00, rd_vld_q} - {2'b00, pop};
   assign rd_issue  = (state_q == ST_RUN) && (rd_left_q != CNT_ZERO) && (occ_sum < 3'd2);

   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      rd_left_d = rd_left_q;
      tx_left_d = tx_left_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rd_ptr_d  = start_addr;
               rd_left_d = len_clamp;
               tx_left_d = len_clamp;
               state_d   = (len_clamp == CNT_ZERO) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_issue) begin
               rd_ptr_d  = rd_ptr_q + PTR_ONE;
               rd_left_d = rd_left_q - CNT_ONE;
            end
            if (pop) begin
               tx_left_d = tx_left_q - CNT_ONE;
               if (tx_left_q == CNT_ONE) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      occ_d     = occ_sum[1:0];
      hd_data_d = hd_data_q;
      hd_last_d = hd_last_q;
      tl_data_d = tl_data_q;
      tl_last_d = tl_last_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               hd_data_d = rd_data_q;
               hd_last_d = rd_last_q;
            end else begin
               tl_data_d = rd_data_q;
               tl_last_d = rd_last_q;
            end
         end
         2'b01: begin
            hd_data_d = tl_data_q;
            hd_last_d = tl_last_q;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               hd_data_d = rd_data_q;
               hd_last_d = rd_last_q;
            end else begin
               hd_data_d = tl_data_q;
               hd_last_d = tl_last_q;
               tl_data_d = rd_data_q;
               tl_last_d = rd_last_q;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         state_q   <= ST_IDLE;
         rd_ptr_q  <= '0;
         rd_left_q <= '0;
         tx_left_q <= '0;
         rd_vld_q  <= 1'b0;
         rd_last_q <= 1'b0;
         occ_q     <= 2'd0;
         hd_data_q <= '0;
         hd_last_q <= 1'b0;
         tl_data_q <= '0;
         tl_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_left_q <= rd_left_d;
         tx_left_q <= tx_left_d;
         rd_vld_q  <= rd_issue;
         rd_last_q <= rd_issue && (rd_left_q == CNT_ONE);
         occ_q     <= occ_d;
         hd_data_q <= hd_data_d;
         hd_last_q <= hd_last_d;
         tl_data_q <= tl_data_d;
         tl_last_q <= tl_last_d;
      end
   end

   // Storage survives reset; rd_vld_q alone decides whether read data is used.
   always_ff @(posedge m_axis_aclk) begin
      if (wr_en && !busy) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_issue) begin
         rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   assign busy          = (state_q == ST_RUN);
   assign done          = (state_q == ST_FIN);
   assign m_axis_tvalid = (occ_q != 2'd0);
   assign m_axis_tdata  = hd_data_q;
   assign m_axis_tlast  = hd_last_q && (occ_q != 2'd0);
   assign m_axis_tstrb  = '1;
   assign m_axis_tkeep  = '1;

endmodule

// File: tb/tb_axis_master_mem.sv
// Bench for axis_master_mem: random backpressure, queue scoreboard fed from a memory model,
// and a negedge monitor that checks beats, stall stability and done timing.

module tb_axis_master_mem;

   logic        clk;
   logic        areset;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic        start;
   logic [6:0]  start_addr;
   logic [7:0]  length;
   logic        busy;
   logic        done;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic [3:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   axis_master_mem dut (
      .m_axis_aclk   (clk),
      .m_axis_areset (areset),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .start         (start),
      .start_addr    (start_addr),
      .length        (length),
      .busy          (busy),
      .done          (done),
      .m_axis_tdata  (tdata),
      .m_axis_tstrb  (tstrb),
      .m_axis_tkeep  (tkeep),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast)
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   int          t_start = 0;
   int          t_last_hs = 0;
   logic [31:0] ref_mem [128];
   logic [31:0] exp_d [$];
   logic        exp_l [$];
   bit          lfsr_on = 0;
   logic [5:0]  lfsr = 6'b000011;

   bit          stall_v = 0;
   logic [31:0] stall_d;
   logic        stall_l;
   bit          last_pend = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (lfsr_on) begin
         tready = lfsr[0];
         lfsr   = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake pops the scoreboard; stalls must hold the beat steady.
   always @(negedge clk) begin
      if (areset) begin
         stall_v   = 0;
         last_pend = 0;
      end else begin
         if (last_pend) begin
            chk("done_after_last", done, 1);
            chk("busy_low_after_last", busy, 0);
            last_pend = 0;
         end
         if (done) done_cnt++;
         if (stall_v) begin
            chk("stall_valid_held", tvalid, 1);
            if (tvalid) begin
               chk("stall_data_stable", tdata, stall_d);
               chk("stall_last_stable", tlast, stall_l);
            end
         end
         if (tvalid && tready) begin
            stall_v = 0;
            if (exp_d.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_beat: got data %0h with no beat expected", tdata);
            end else begin
               logic [31:0] ed;
               logic        el;
               ed = exp_d.pop_front();
               el = exp_l.pop_front();
               chk("beat_data", tdata, ed);
               chk("beat_last", tlast, el);
               if (el) begin
                  last_pend = 1;
                  t_last_hs = cyc + 1;
               end
            end
            hs_cnt++;
         end else if (tvalid) begin
            stall_v = 1;
            stall_d = tdata;
            stall_l = tlast;
         end else begin
            stall_v = 0;
         end
      end
   end

   task automatic do_start(input logic [6:0] sa, input logic [7:0] len, input bit completes);
      int l;
      tick();
      l = (len > 8'd128) ? 128 : int'(len);
      start      = 1'b1;
      start_addr = sa;
      length     = len;
      for (int k = 0; k < l; k++) begin
         exp_d.push_back(ref_mem[(int'(sa) + k) % 128]);
         exp_l.push_back(k == l - 1);
      end
      tick();
      start   = 1'b0;
      t_start = cyc;
      if (l > 0) chk("busy_after_start", busy, 1);
      if (completes) exp_done++;
   endtask

   task automatic finish_xfer(input int l, input bit check_lat, input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done) begin
            ok = 1;
            break;
         end
      end
      chk("done_seen", ok, 1);
      chk("beats_outstanding", exp_d.size(), 0);
      if (ok && check_lat) chk("start_to_last_cycles", t_last_hs - t_start, l + 2);
   endtask

   task automatic wait_beats(input int target, input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (hs_cnt >= target) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk(nm, ok, 1);
   endtask

   initial begin
      int d0;
      int base;
      areset     = 1'b1;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      start      = 1'b0;
      start_addr = '0;
      length     = '0;
      tready     = 1'b1;
      repeat (3) tick();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("tstrb_ones", tstrb, 4'hF);
      chk("tkeep_ones", tkeep, 4'hF);
      areset = 1'b0;

      for (int i = 0; i < 128; i++) begin
         wr_en      = 1'b1;
         wr_addr    = 7'(i);
         wr_data    = 32'(i);
         ref_mem[i] = 32'(i);
         tick();
      end
      wr_en = 1'b0;

      // full block, free-running sink
      do_start(7'd0, 8'd128, 1);
      finish_xfer(128, 1, 400);

      // same block under LFSR backpressure
      lfsr    = 6'b000011;
      lfsr_on = 1;
      do_start(7'd0, 8'd128, 1);
      finish_xfer(128, 0, 2000);
      lfsr_on = 0;
      tick();
      tready = 1'b1;

      // wrap across the top of memory
      do_start(7'd120, 8'd16, 1);
      finish_xfer(16, 1, 200);

      // zero length: a lone done pulse, no beats
      do_start(7'd9, 8'd0, 1);
      d0 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (done) d0++;
         chk("len0_no_tvalid", tvalid, 0);
      end
      chk("len0_done_pulses", d0, 1);

      do_start(7'd37, 8'd1, 1);
      finish_xfer(1, 1, 100);

      do_start(7'd5, 8'd200, 1);
      finish_xfer(128, 1, 400);

      // start and writes while busy are ignored
      lfsr_on = 1;
      base = hs_cnt;
      do_start(7'd0, 8'd128, 1);
      wait_beats(base + 10, "busy_test_progress");
      chk("busy_during_ignored", busy, 1);
      start      = 1'b1;
      start_addr = 7'd50;
      length     = 8'd3;
      tick();
      start   = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 7'd5;
      wr_data = 32'hDEAD_0005;
      tick();
      wr_addr = 7'd100;
      wr_data = 32'hDEAD_0100;
      tick();
      wr_en = 1'b0;
      finish_xfer(128, 0, 2000);
      lfsr_on = 0;
      tick();
      tready = 1'b1;
      do_start(7'd0, 8'd128, 1);
      finish_xfer(128, 1, 400);

      // a write while idle does land
      tick();
      wr_en      = 1'b1;
      wr_addr    = 7'd5;
      wr_data    = 32'hA5A5_0005;
      ref_mem[5] = 32'hA5A5_0005;
      tick();
      wr_en = 1'b0;
      do_start(7'd4, 8'd3, 1);
      finish_xfer(3, 1, 100);

      // reset in the middle of a stream
      base = hs_cnt;
      do_start(7'd0, 8'd128, 0);
      wait_beats(base + 40, "reset_test_progress");
      tready = 1'b0;
      areset = 1'b1;
      tick();
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_tlast", tlast, 0);
      chk("midrst_tdata", tdata, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      areset = 1'b0;
      exp_d.delete();
      exp_l.delete();
      tready = 1'b1;
      repeat (4) tick();
      do_start(7'd0, 8'd128, 1);
      finish_xfer(128, 1, 400);

      repeat (3) tick();
      chk("done_pulse_count", done_cnt, exp_done);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

endmodule
